// File: rtl/mux_9_pkg.sv
// Shared types, constants and the round-robin pick function for the 9-way arbitrated mux.
package mux_9_pkg;

  localparam int         N_SRC      = 9;
  localparam int         SRC_W      = 4;
  localparam logic [3:0] SRC_NONE   = 4'd15;
  localparam logic [3:0] LAST_RESET = 4'd8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Scan last+1 .. last+9 (mod 9); walking backwards leaves the earliest hit in the result.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [N_SRC-1:0]  req,
                                               input logic [SRC_W-1:0] last);
    logic [SRC_W-1:0] idx;
    int               sum;
    rr_pick = SRC_NONE;
    for (int k = N_SRC; k >= 1; k--) begin
      sum = int'(last) + k;
      if (sum >= N_SRC) sum = sum - N_SRC;
      if (sum >= N_SRC) sum = sum - N_SRC;
      idx = SRC_W'(sum);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_9.sv
// Combinational 9:1 word mux; any select outside 0..8 yields all-ones.
module mux_9 #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] e,
  input  logic [DW-1:0] f,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] h,
  input  logic [DW-1:0] i,
  input  logic [3:0]    sel,
  output logic [DW-1:0] out
);

  always_comb begin
    out = '1;
    case (sel)
      4'd0:    out = a;
      4'd1:    out = b;
      4'd2:    out = c;
      4'd3:    out = d;
      4'd4:    out = e;
      4'd5:    out = f;
      4'd6:    out = g;
      4'd7:    out = h;
      4'd8:    out = i;
      default: out = '1;
    endcase
  end

endmodule

// File: rtl/mux_9_rr_arb.sv
// Round-robin arbiter over 9 sources feeding one registered valid/ready output stage.
// Grant-to-output latency is one cycle; a stalled output holds and suppresses all grants.
module mux_9_rr_arb
  import mux_9_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [DW-1:0]    c,
  input  logic [DW-1:0]    d,
  input  logic [DW-1:0]    e,
  input  logic [DW-1:0]    f,
  input  logic [DW-1:0]    g,
  input  logic [DW-1:0]    h,
  input  logic [DW-1:0]    i,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] gnt,
  output logic [DW-1:0]    out,
  output logic [SRC_W-1:0] out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  out_state_t       state_q, state_d;
  logic [DW-1:0]    out_q, out_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] last_q, last_d;

  logic [SRC_W-1:0] pick_sel;
  logic [DW-1:0]    mux_out;
  logic             load;

  assign pick_sel = rr_pick(req, last_q);
  assign load     = (|req) && ((state_q == ST_EMPTY) || out_ready) && !rst;

  mux_9 #(.DW(DW)) u_mux_9 (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .i   (i),
    .sel (pick_sel),
    .out (mux_out)
  );

  // A full stage that drains and reloads in the same cycle takes the load branch.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    src_d   = src_q;
    last_d  = last_q;
    gnt     = '0;
    if (load) begin
      gnt     = 9'(1) << pick_sel;
      state_d = ST_FULL;
      out_d   = mux_out;
      src_d   = pick_sel;
      last_d  = pick_sel;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
      out_d   = '1;
      src_d   = SRC_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '1;
      src_q   <= SRC_NONE;
      last_q  <= LAST_RESET;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign out       = out_q;
  assign out_src   = src_q;
  assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux_9_rr_arb.sv
// Bench for mux_9_rr_arb: directed scenarios plus randomized traffic against a queue-free reference model.
module tb_mux_9_rr_arb;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] dw [9];
  logic [DW-1:0] a, b, c, d, e, f, g, h, i;
  logic [8:0]    req = '0;
  logic [8:0]    gnt;
  logic [DW-1:0] out;
  logic [3:0]    out_src;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  assign a = dw[0];
  assign b = dw[1];
  assign c = dw[2];
  assign d = dw[3];
  assign e = dw[4];
  assign f = dw[5];
  assign g = dw[6];
  assign h = dw[7];
  assign i = dw[8];

  always #5 clk = ~clk;

  mux_9_rr_arb #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .i         (i),
    .req       (req),
    .gnt       (gnt),
    .out       (out),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic set_pattern_words();
    for (int k = 0; k < 9; k++) dw[k] = DW'(k) * 32'h11111111;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_pattern_words();
    rst = 1'b1;
    req = 9'h1FF;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 9'h000) begin errors++; $display("FAIL reset_gnt got %h want 000", gnt); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++;
    if (out !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_out got %h want ffffffff", out); end
    checks++;
    if (out_src !== 4'd15) begin errors++; $display("FAIL reset_src got %0d want 15", out_src); end
    // Load a word, then reset between edges.
    rst = 1'b0;
    req = 9'h001;
    @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_preload_valid got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 32'hFFFFFFFF || out_src !== 4'd15)
      begin errors++; $display("FAIL reset_async got v=%b out=%h src=%0d want v=0 out=ffffffff src=15", out_valid, out, out_src); end
    @(negedge clk);
    req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    req = 9'h008;
    #1;
    checks++;
    if (gnt !== 9'h008) begin errors++; $display("FAIL single_gnt got %h want 008", gnt); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out !== 32'h33333333 || out_src !== 4'd3)
      begin errors++; $display("FAIL single_out got v=%b out=%h src=%0d want v=1 out=33333333 src=3", out_valid, out, out_src); end
    req = '0;
    #1;
    checks++;
    if (gnt !== 9'h000) begin errors++; $display("FAIL single_idle_gnt got %h want 000", gnt); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out !== 32'hFFFFFFFF || out_src !== 4'd15)
      begin errors++; $display("FAIL single_drain got v=%b out=%h src=%0d want v=0 out=ffffffff src=15", out_valid, out, out_src); end
  endtask

  task automatic test_rotation();
    int exp_k;
    do_reset();
    out_ready = 1'b1;
    req = 9'h1FF;
    for (int n = 0; n < 10; n++) begin
      exp_k = n % 9;
      #1;
      checks++;
      if (gnt !== (9'h001 << exp_k)) begin errors++; $display("FAIL rotation_gnt[%0d] got %h want %h", n, gnt, 9'h001 << exp_k); end
      @(negedge clk);
      checks++;
      if (out !== DW'(exp_k) * 32'h11111111 || out_src !== 4'(exp_k) || out_valid !== 1'b1)
        begin errors++; $display("FAIL rotation_out[%0d] got out=%h src=%0d v=%b want src=%0d", n, out, out_src, out_valid, exp_k); end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    req = 9'h022;
    #1;
    checks++;
    if (gnt !== 9'h002) begin errors++; $display("FAIL bp_first_gnt got %h want 002", gnt); end
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (gnt !== 9'h000 || out !== 32'h11111111 || out_src !== 4'd1 || out_valid !== 1'b1)
        begin errors++; $display("FAIL bp_stall[%0d] got gnt=%h out=%h src=%0d v=%b want gnt=000 out=11111111 src=1 v=1", n, gnt, out, out_src, out_valid); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (gnt !== 9'h020) begin errors++; $display("FAIL bp_release_gnt got %h want 020", gnt); end
    @(negedge clk);
    checks++;
    if (out !== 32'h55555555 || out_src !== 4'd5)
      begin errors++; $display("FAIL bp_release_out got out=%h src=%0d want 55555555 src=5", out, out_src); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_rr_order();
    do_reset();
    out_ready = 1'b1;
    req = 9'h080;
    @(negedge clk);
    checks++;
    if (out_src !== 4'd7) begin errors++; $display("FAIL rr_prime got src=%0d want 7", out_src); end
    req = 9'h104;
    #1;
    checks++;
    if (gnt !== 9'h100) begin errors++; $display("FAIL rr_gnt0 got %h want 100", gnt); end
    @(negedge clk);
    checks++;
    if (out_src !== 4'd8) begin errors++; $display("FAIL rr_src0 got %0d want 8", out_src); end
    #1;
    checks++;
    if (gnt !== 9'h004) begin errors++; $display("FAIL rr_gnt1 got %h want 004", gnt); end
    @(negedge clk);
    checks++;
    if (out_src !== 4'd2 || out !== 32'h22222222)
      begin errors++; $display("FAIL rr_src1 got src=%0d out=%h want 2 22222222", out_src, out); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    req = 9'h010;
    @(negedge clk);
    out_ready = 1'b0;
    req = 9'h020;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 32'hFFFFFFFF)
      begin errors++; $display("FAIL mid_reset got v=%b out=%h want v=0 out=ffffffff", out_valid, out); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    req = 9'h101;
    #1;
    checks++;
    if (gnt !== 9'h001) begin errors++; $display("FAIL mid_gnt0 got %h want 001", gnt); end
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 9'h100 || out_src !== 4'd0) begin errors++; $display("FAIL mid_gnt1 got gnt=%h src=%0d want 100 src=0", gnt, out_src); end
    @(negedge clk);
    checks++;
    if (out_src !== 4'd8) begin errors++; $display("FAIL mid_src1 got %0d want 8", out_src); end
    req = '0;
    @(negedge clk);
  endtask

  // Reference: remember the last granted index and what the output stage holds.
  task automatic test_random();
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_out   = '1;
    int            m_src   = 15;
    int            m_last  = 8;
    int            win;
    bit            m_load;
    logic [8:0]    exp_gnt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (out_valid !== m_valid || out !== m_out || out_src !== 4'(m_src))
        begin errors++; $display("FAIL rand_out[%0d] got v=%b out=%h src=%0d want v=%b out=%h src=%0d", n, out_valid, out, out_src, m_valid, m_out, m_src); end
      for (int k = 0; k < 9; k++) if ($urandom_range(3) == 0) dw[k] = $urandom;
      req = ($urandom_range(4) == 0) ? 9'h000 : 9'($urandom);
      out_ready = ($urandom_range(3) != 0);
      win = -1;
      for (int s = 1; s <= 9; s++)
        if (win < 0 && req[(m_last + s) % 9]) win = (m_last + s) % 9;
      m_load  = (win >= 0) && (!m_valid || out_ready);
      exp_gnt = m_load ? (9'h001 << win) : 9'h000;
      #1;
      checks++;
      if (gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt[%0d] got %h want %h", n, gnt, exp_gnt); end
      if (m_load) begin
        m_valid = 1'b1;
        m_out   = dw[win];
        m_src   = win;
        m_last  = win;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_out   = '1;
        m_src   = 15;
      end
      @(negedge clk);
    end
    req = '0;
  endtask

  initial begin
    set_pattern_words();
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_rr_order();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
